// File: rtl/noc_pkg.sv
// Shared types and helpers for the router route-reservation logic.
package noc_pkg;

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // Smallest index width that can name every one of n ports (at least 1 bit).
    function automatic int reqWidthFor(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among N requesters, starting the search at ptr.
// Latency: purely combinational.
// Backpressure: none; grantValid is low when no request is present.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic         grantValid
);

    int bestDist;

    // Winner is the requester with the smallest circular distance from ptr.
    always_comb begin
        bestDist   = N;
        grant      = '0;
        grantValid = |req;
        for (int i = 0; i < N; i++) begin
            if (req[i] && ((i - int'(ptr) + N) % N) < bestDist) begin
                bestDist = (i - int'(ptr) + N) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            grant[i] = req[i] && (((i - int'(ptr) + N) % N) == bestDist);
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output route reservation: round-robin grant, locked until the owner relieves.
// Latency: request sampled at one edge, grant visible right after it (1 cycle).
// Backpressure: ungranted requests simply stay pending; ports hold req_valid until granted.
module switch_allocator
    import noc_pkg::*;
#(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = reqWidthFor(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    input  logic [N*REQUEST_WIDTH-1:0] req_dest,
    input  logic [N-1:0]             relieve,
    output logic [N-1:0]             grant_status,
    output logic [N*REQUEST_WIDTH-1:0] out_sel,
    output logic [N-1:0]             out_busy
);

    localparam int W = REQUEST_WIDTH;

    alloc_state_t state     [N];
    alloc_state_t nextState [N];
    logic [W-1:0] owner     [N];
    logic [W-1:0] nextOwner [N];
    logic [W-1:0] ptr       [N];
    logic [W-1:0] nextPtr   [N];
    logic [W-1:0] winner    [N];
    logic [N-1:0] eligible  [N];
    logic [N-1:0] arbGrant  [N];
    logic [N-1:0] arbValid;
    logic [N-1:0] isOwner;
    logic [N-1:0] ownerRelieve;
    logic [N-1:0] nextGrant;

    // Out-of-range destinations never equal any output index, so they drop out here.
    always_comb begin
        isOwner      = '0;
        ownerRelieve = '0;
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                if (state[o] == LOCKED && owner[o] == W'(i)) begin
                    isOwner[i] = 1'b1;
                    if (relieve[i]) ownerRelieve[o] = 1'b1;
                end
            end
        end
        for (int o = 0; o < N; o++) begin
            eligible[o] = '0;
            for (int i = 0; i < N; i++) begin
                eligible[o][i] = req_valid[i] && !isOwner[i]
                                 && (int'(req_dest[i*W +: W]) == o);
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : gArb
        rr_arbiter #(.N(N), .W(W)) uArb (
            .req        (eligible[g]),
            .ptr        (ptr[g]),
            .grant      (arbGrant[g]),
            .grantValid (arbValid[g])
        );
    end

    // A released output is never re-granted in the same edge, leaving one idle cycle.
    always_comb begin
        nextGrant = '0;
        for (int o = 0; o < N; o++) begin
            winner[o] = '0;
            for (int i = 0; i < N; i++) begin
                if (arbGrant[o][i]) winner[o] = W'(i);
            end
            nextState[o] = state[o];
            nextOwner[o] = owner[o];
            nextPtr[o]   = ptr[o];
            if (state[o] == LOCKED) begin
                if (ownerRelieve[o]) begin
                    nextState[o] = FREE;
                    nextOwner[o] = '0;
                end
            end else if (arbValid[o]) begin
                nextState[o] = LOCKED;
                nextOwner[o] = winner[o];
                nextPtr[o]   = W'((int'(winner[o]) + 1) % N);
            end
            for (int i = 0; i < N; i++) begin
                if (nextState[o] == LOCKED && nextOwner[o] == W'(i)) nextGrant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < N; o++) begin
                state[o] <= FREE;
                owner[o] <= '0;
                ptr[o]   <= '0;
            end
            grant_status <= '0;
            out_busy     <= '0;
            out_sel      <= '0;
        end else begin
            for (int o = 0; o < N; o++) begin
                state[o]             <= nextState[o];
                owner[o]             <= nextOwner[o];
                ptr[o]               <= nextPtr[o];
                out_busy[o]          <= (nextState[o] == LOCKED);
                out_sel[o*W +: W]    <= nextOwner[o];
            end
            grant_status <= nextGrant;
        end
    end

endmodule
